pch_unit: RTL
=============

Name: pch_unit

Overview:
- Program Counter High unit for the cpu6502 core: the high-byte half of the program counter.
- Consumes the low-byte carry (pclc) produced by the program-counter-low logic, loads from the ADH bus, and holds PCH.
- Adds a one-cycle branch page-cross fixup sequencer that increments or decrements PCH after a relative branch carries or borrows out of the low byte.
- Registered state updates on the falling edge of i_clk (phi2 latch), gated by i_clk_en.

Parameters:
- RESET_VALUE, 8'h00, value loaded into PCH on reset.

Ports:
- i_clk  input  1  system clock; all state updates on negedge i_clk.
- i_reset  input  1  synchronous, active-high reset, sampled on negedge i_clk.
- i_clk_en  input  1  clock enable; when low, all state (PCH, FSM, pulses) holds.
- i_pch_pch  input  1  control: PCH select takes current PCH.
- i_adh_pch  input  1  control: PCH select takes ADH bus.
- i_adh  input  8  ADH bus.
- i_pclc  input  1  carry in from the low-byte increment logic.
- i_fix_req  input  1  request a page-cross fixup, one cycle.
- i_fix_dir  input  1  fixup direction: 0 = +1 (forward branch), 1 = -1 (backward branch).
- o_pch  output  8  PCH register.
- o_pchc  output  1  combinational carry out: PC wraps FFFF->0000.
- o_fix_busy  output  1  high while in FIX state.
- o_fix_done  output  1  one-cycle pulse after fixup write.

Behaviour:
- Reset (i_reset=1 at negedge, regardless of i_clk_en):
  - o_pch=RESET_VALUE.
  - FSM=IDLE; o_fix_busy=0; o_fix_done=0.
  - Latched direction cleared.
- PCHS mux (combinational), in priority order:
  - i_pch_pch -> o_pch;
  - else i_adh_pch -> i_adh;
  - else 8'h00.
- Increment: pchs_inc = PCHS + i_pclc, modulo 256.
- o_pchc = i_pclc && (PCHS==8'hFF). Combinational and independent of FSM state.
- FSM states:
  - IDLE:
    - Each enabled negedge: o_pch <= pchs_inc.
    - If i_fix_req=1 in the same cycle: latch i_fix_dir and go to FIX. The normal update still occurs that cycle.
  - FIX:
    - o_fix_busy=1.
    - Next enabled negedge: o_pch <= o_pch+1 (dir 0) or o_pch-1 (dir 1), modulo 256 (FF+1=00, 00-1=FF).
    - i_pch_pch, i_adh_pch, i_pclc and i_fix_req are ignored; o_pchc is still driven combinationally.
    - Go to DONE.
  - DONE:
    - o_fix_done=1 for exactly one enabled cycle.
    - Normal PCHS update applies as in IDLE.
    - A new i_fix_req here is accepted (back-to-back) -> FIX.
    - Otherwise -> IDLE.
- Latency:
  - Fixup result is visible on o_pch 2 enabled cycles after the cycle sampling i_fix_req (1 normal update, then 1 fixup).
  - o_fix_done asserts the cycle after the fixup write.
- Clock enable: when i_clk_en=0, o_pch, FSM, latched direction and o_fix_done all hold. A pending FIX waits for the next enabled edge.
- Reset mid-fixup (in FIX or DONE): abort to IDLE, o_pch=RESET_VALUE, no done pulse.
- Both i_pch_pch and i_adh_pch high: i_pch_pch wins.
- Fixup request while busy (FIX state): dropped, not queued.

Test Plan:
- Reset, then i_adh_pch=1, i_adh=8'h80, i_pclc=0, one enabled edge -> o_pch=8'h80; assert i_reset -> o_pch=8'h00, o_fix_busy=0.
- o_pch=8'h12, i_pch_pch=1, i_pclc=1 -> o_pch=8'h13, o_pchc=0. Then o_pch=8'hFF, i_pclc=1 -> o_pchc=1 before the edge, o_pch=8'h00 after it.
- o_pch=8'h20, i_pch_pch=1, i_fix_req=1, i_fix_dir=1, i_pclc=0:
  - edge1 -> o_pch=8'h20, o_fix_busy=1;
  - edge2 -> o_pch=8'h1F, o_fix_done=1;
  - edge3 -> o_fix_done=0.
- Forward fixup from o_pch=8'hFF, dir=0 -> o_pch=8'h00 after FIX. During FIX, drive i_adh_pch=1, i_adh=8'h55 -> ignored, o_pch≠8'h55.
- In FIX, hold i_clk_en=0 for 3 edges -> o_pch and o_fix_busy unchanged; raise i_clk_en -> fixup completes on the first enabled edge.
- Assert i_reset in FIX state -> next edge o_pch=RESET_VALUE, o_fix_busy=0, no o_fix_done pulse. Also cover back-to-back i_fix_req in DONE -> re-enters FIX.

Source files
------------

// File: rtl/pch_unit.sv
// rtl/pch_unit.sv - program counter high byte with branch page-cross fixup
// PCH loads from the PCHS mux plus low-byte carry; a FIX cycle then nudges it by +/-1.
module pch_unit #(
  parameter logic [7:0] RESET_VALUE = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_clk_en,
  input  logic       i_pch_pch,
  input  logic       i_adh_pch,
  input  logic [7:0] i_adh,
  input  logic       i_pclc,
  input  logic       i_fix_req,
  input  logic       i_fix_dir,
  output logic [7:0] o_pch,
  output logic       o_pchc,
  output logic       o_fix_busy,
  output logic       o_fix_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIX  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pch_q, pch_d;
  logic       dir_q, dir_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] pchs;
  logic [7:0] pchs_inc;

  always_comb begin
    if (i_pch_pch) begin
      pchs = pch_q;
    end else if (i_adh_pch) begin
      pchs = i_adh;
    end else begin
      pchs = 8'h00;
    end
  end

  assign pchs_inc = pchs + {7'd0, i_pclc};
  // Carry out only when the whole 16-bit PC wraps, so it depends on PCHS, not FSM state.
  assign o_pchc   = i_pclc & (pchs == 8'hFF);

  always_comb begin
    state_d = state_q;
    pch_d   = pch_q;
    dir_d   = dir_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        pch_d = pchs_inc;
        if (i_fix_req) begin
          dir_d   = i_fix_dir;
          state_d = ST_FIX;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end
      end
      ST_FIX: begin
        // Bus controls and new requests are ignored; only the latched direction matters.
        pch_d   = dir_q ? (pch_q - 8'd1) : (pch_q + 8'd1);
        state_d = ST_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // phi2 latch: state advances on the falling edge.
  always_ff @(negedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      pch_q   <= RESET_VALUE;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (i_clk_en) begin
      state_q <= state_d;
      pch_q   <= pch_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_pch      = pch_q;
  assign o_fix_busy = busy_q;
  assign o_fix_done = done_q;

endmodule
